alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
//  Decode stage driving the ALU: accepts fetched RV32I instruction words, produces alu_ctrl/ext
//  (`ALU_* macros from defs.sv), operand selects and a sign-extended immediate. Registered output
//  with valid/ready on both sides and a skid buffer so in_ready is a flop. Counts illegal encodings.
// PARAMETERS
//  PC_WIDTH  32  width of pc passthrough
//  SKID      1   1: 2-entry skid buffer, registered in_ready; 0: single stage,
//                in_ready = !out_valid | out_ready
//  CNT_WIDTH 16  width of saturating illegal-instruction counter
// PORTS
//  clk         in   1         clock, all state updates on posedge
//  rst         in   1         synchronous, active-high reset
//  flush       in   1         sync clear of all buffered entries
//  in_valid    in   1         instruction word valid
//  in_ready    out  1         stage can accept
//  in_instr    in   32        instruction word
//  in_pc       in   PC_WIDTH  pc of in_instr
//  out_valid   out  1         decoded entry valid
//  out_ready   in   1         ALU/execute side accepts
//  alu_ctrl    out  4         `ALU_* code
//  ext         out  1         1 = arithmetic right shift (SRA/SRAI)
//  src1_sel    out  2         0 rs1, 1 pc, 2 zero
//  src2_sel    out  1         0 rs2, 1 imm
//  imm         out  32        sign-extended immediate (0 for R-type)
//  illegal     out  1         entry is an illegal encoding (alu_ctrl=`ALU_ADD, ext=0)
//  pc_out      out  PC_WIDTH  pc passthrough
//  illegal_cnt out  CNT_WIDTH illegal entries accepted on input, saturating
// BEHAVIOUR
//  Reset/flush: out_valid=0, buffers empty, in_ready=1 (next cycle), payload outputs 0.
//   Reset clears illegal_cnt; flush does not. rst has priority over flush; a flush cycle
//   accepts no input and transfers no output.
//  Handshake: transfer in on in_valid&in_ready, out on out_valid&out_ready. Latency 1 cycle
//   (accept in cycle N -> out_valid in N+1). Payload stable while out_valid&!out_ready.
//  SKID=1: states EMPTY, ONE (main reg full), TWO (main+skid full, in_ready=0).
//   EMPTY-in->ONE; ONE: in&!out->TWO, out&!in->EMPTY, in&out->ONE; TWO: out->ONE (skid moves to
//   main). in_ready = state!=TWO, registered. Order preserved, no bubbles at full throughput.
//  Decode by opcode[6:0]:
//   0110011 OP: f3 000 ADD/SUB(f7[5]), 001 SL, 010 SLT, 011 SLTU, 100 XOR, 101 SR ext=f7[5],
//     110 OR, 111 AND; src2=rs2. f7 not 0x00 and not 0x20, or 0x20 with f3 not 000/101 -> illegal.
//   0010011 OP-IMM: as OP, never SUB; src2=imm I-type; shifts imm={27'b0,shamt}, f7 rules as OP,
//     f7[5] only legal for f3=101.
//   0110111 LUI: ADD, src1=zero, imm=U. 0010111 AUIPC: ADD, src1=pc, imm=U.
//   0000011 LOAD / 1100111 JALR: ADD, imm=I. 0100011 STORE: ADD, imm=S.
//   1100011 BRANCH: f3 000/001 SUB, 100/101 SLT, 110/111 SLTU; src2=rs2; imm=B; 010/011 illegal.
//   1101111 JAL: ADD, src1=pc, imm=J. Any other opcode, or instr[1:0]!=11 -> illegal.
//  illegal_cnt: +1 per accepted illegal word; holds at all-ones.
// TESTING
//  ADD x1,x2,x3 (0x003100B3) -> next cycle alu_ctrl=`ALU_ADD, src2_sel=0, imm=0, illegal=0
//  SRAI x1,x2,5 (0x40515093) -> `ALU_SR, ext=1, src2_sel=1, imm=5; SRLI (0x00515093) ext=0
//  ADDI x1,x0,-1 (0xFFF00093) -> imm=0xFFFFFFFF; LUI 0x12345 -> src1_sel=2, imm=0x12345000
//  Stream 8 words with out_ready low 3 cycles: in_ready drops after 2 accepts, all 8 emerge in order
//  0xFFFFFFFF, 0x00000000, BRANCH f3=010 -> illegal=1 each, illegal_cnt=3; flush with 2 queued ->
//   out_valid=0 next cycle, cnt stays 3; rst -> cnt=0

Source files
------------

// File: rtl/alu_op_decoder.sv
// RV32I decode stage feeding the ALU: registered decoded payload with valid/ready on both
// sides, optional 2-entry skid buffer, and a saturating count of illegal instruction words.
`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_SL   4'd2
`define ALU_SLT  4'd3
`define ALU_SLTU 4'd4
`define ALU_XOR  4'd5
`define ALU_SR   4'd6
`define ALU_OR   4'd7
`define ALU_AND  4'd8
`endif

module alu_op_decoder #(
    parameter int PC_WIDTH  = 32,
    parameter int SKID      = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_ctrl,
    output logic                 ext,
    output logic [1:0]           src1_sel,
    output logic                 src2_sel,
    output logic [31:0]          imm,
    output logic                 illegal,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    localparam bit USE_SKID = (SKID != 32'sd0);

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        ext;
        logic [1:0]  src1_sel;
        logic        src2_sel;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        dec_t                d;
        logic [PC_WIDTH-1:0] pc;
    } pay_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    function automatic dec_t decode_instr(input logic [31:0] i);
        dec_t       d;
        dec_t       bad;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       f7_ok;
        logic [31:0] imm_i;
        d      = '0;
        bad    = '0;
        bad.illegal = 1'b1;
        f3     = i[14:12];
        f7     = i[31:25];
        f7_ok  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
        imm_i  = {{20{i[31]}}, i[31:20]};
        if (i[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (i[6:0])
                7'b0110011: begin
                    d.illegal = !f7_ok;
                    case (f3)
                        3'b000:  d.alu_ctrl = f7[5] ? `ALU_SUB : `ALU_ADD;
                        3'b001:  d.alu_ctrl = `ALU_SL;
                        3'b010:  d.alu_ctrl = `ALU_SLT;
                        3'b011:  d.alu_ctrl = `ALU_SLTU;
                        3'b100:  d.alu_ctrl = `ALU_XOR;
                        3'b101:  begin d.alu_ctrl = `ALU_SR; d.ext = f7[5]; end
                        3'b110:  d.alu_ctrl = `ALU_OR;
                        default: d.alu_ctrl = `ALU_AND;
                    endcase
                end
                7'b0010011: begin
                    // Only the shift forms carry a funct7; other OP-IMM bits are immediate
                    d.src2_sel = 1'b1;
                    d.imm      = imm_i;
                    case (f3)
                        3'b000:  d.alu_ctrl = `ALU_ADD;
                        3'b001:  begin
                            d.alu_ctrl = `ALU_SL;
                            d.imm      = {27'd0, i[24:20]};
                            d.illegal  = (f7 != 7'h00);
                        end
                        3'b010:  d.alu_ctrl = `ALU_SLT;
                        3'b011:  d.alu_ctrl = `ALU_SLTU;
                        3'b100:  d.alu_ctrl = `ALU_XOR;
                        3'b101:  begin
                            d.alu_ctrl = `ALU_SR;
                            d.ext      = f7[5];
                            d.imm      = {27'd0, i[24:20]};
                            d.illegal  = !f7_ok;
                        end
                        3'b110:  d.alu_ctrl = `ALU_OR;
                        default: d.alu_ctrl = `ALU_AND;
                    endcase
                end
                7'b0110111: begin d.src1_sel = 2'd2; d.src2_sel = 1'b1; d.imm = {i[31:12], 12'd0}; end
                7'b0010111: begin d.src1_sel = 2'd1; d.src2_sel = 1'b1; d.imm = {i[31:12], 12'd0}; end
                7'b0000011, 7'b1100111: begin d.src2_sel = 1'b1; d.imm = imm_i; end
                7'b0100011: begin
                    d.src2_sel = 1'b1;
                    d.imm      = {{20{i[31]}}, i[31:25], i[11:7]};
                end
                7'b1100011: begin
                    d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                    case (f3)
                        3'b000, 3'b001: d.alu_ctrl = `ALU_SUB;
                        3'b100, 3'b101: d.alu_ctrl = `ALU_SLT;
                        3'b110, 3'b111: d.alu_ctrl = `ALU_SLTU;
                        default:        d.illegal  = 1'b1;
                    endcase
                end
                7'b1101111: begin
                    d.src1_sel = 2'd1;
                    d.src2_sel = 1'b1;
                    d.imm      = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                end
                default: d.illegal = 1'b1;
            endcase
        end
        return d.illegal ? bad : d;
    endfunction

    state_t               state_r;
    pay_t                 main_r;
    pay_t                 skid_r;
    pay_t                 pay_s;
    logic                 out_valid_r;
    logic                 in_ready_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 acc_s;
    logic                 deq_s;

    // Decode the incoming word and form the handshake strobes
    always_comb begin
        pay_s.d  = decode_instr(in_instr);
        pay_s.pc = in_pc;
        in_ready = USE_SKID ? in_ready_r : (!out_valid_r || out_ready);
        acc_s    = in_valid && in_ready && !flush;
        deq_s    = out_valid_r && out_ready && !flush;
    end

    // Buffer occupancy, payload registers and the illegal-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            cnt_r       <= '0;
        end else if (flush) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            if (acc_s && pay_s.d.illegal && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
            if (USE_SKID) begin
                case (state_r)
                    EMPTY: begin
                        if (acc_s) begin
                            main_r      <= pay_s;
                            out_valid_r <= 1'b1;
                            state_r     <= ONE;
                        end
                    end
                    ONE: begin
                        if (acc_s && !deq_s) begin
                            skid_r     <= pay_s;
                            state_r    <= TWO;
                            in_ready_r <= 1'b0;
                        end else if (deq_s && !acc_s) begin
                            out_valid_r <= 1'b0;
                            state_r     <= EMPTY;
                        end else if (acc_s && deq_s) begin
                            main_r <= pay_s;
                        end
                    end
                    TWO: begin
                        // Older entry leaves; the skid entry becomes the head
                        if (deq_s) begin
                            main_r     <= skid_r;
                            state_r    <= ONE;
                            in_ready_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                endcase
            end else begin
                if (acc_s) begin
                    main_r      <= pay_s;
                    out_valid_r <= 1'b1;
                end else if (deq_s) begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign alu_ctrl    = main_r.d.alu_ctrl;
    assign ext         = main_r.d.ext;
    assign src1_sel    = main_r.d.src1_sel;
    assign src2_sel    = main_r.d.src2_sel;
    assign imm         = main_r.d.imm;
    assign illegal     = main_r.d.illegal;
    assign pc_out      = main_r.pc;
    assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder: single decodes, a stalled 8-word stream,
// illegal counting, flush and reset.
module tb_alu_op_decoder;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SL = 4'd2, A_SLT = 4'd3,
                           A_SLTU = 4'd4, A_SR = 4'd6;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, imm, pc_out;
    logic [3:0]  alu_ctrl;
    logic        ext, src2_sel, illegal;
    logic [1:0]  src1_sel;
    logic [15:0] illegal_cnt;

    int total = 0;
    int bad   = 0;

    alu_op_decoder #(.PC_WIDTH(32), .SKID(1), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .ext(ext), .src1_sel(src1_sel), .src2_sel(src2_sel), .imm(imm),
        .illegal(illegal), .pc_out(pc_out), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one cycle; returns at the negedge where its decode is visible
    task automatic send_one(input logic [31:0] w, input logic [31:0] pc);
        in_instr = w;
        in_pc    = pc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_dec(input string tag, input logic [3:0] a, input logic e,
                           input logic [1:0] s1, input logic s2, input logic [31:0] im,
                           input logic il, input logic [31:0] pc);
        chk({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, ".fields"}, {45'd0, a, e, s1, s2, il, 9'd0},
            {45'd0, alu_ctrl, ext, src1_sel, src2_sel, illegal, 9'd0});
        chk({tag, ".imm"}, {32'd0, imm}, {32'd0, im});
        chk({tag, ".pc"}, {32'd0, pc_out}, {32'd0, pc});
    endtask

    logic [31:0] exp_pc[$];
    int sent, rcv, cyc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst.cnt", {48'd0, illegal_cnt}, 64'd0);
        chk("rst.payload", {28'd0, alu_ctrl, imm}, 64'd0);

        send_one(32'h003100B3, 32'h100); chk_dec("add",   A_ADD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h100);
        send_one(32'h403100B3, 32'h104); chk_dec("sub",   A_SUB, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h104);
        send_one(32'h40515093, 32'h108); chk_dec("srai",  A_SR,  1'b1, 2'd0, 1'b1, 32'd5, 1'b0, 32'h108);
        send_one(32'h00515093, 32'h10C); chk_dec("srli",  A_SR,  1'b0, 2'd0, 1'b1, 32'd5, 1'b0, 32'h10C);
        send_one(32'hFFF00093, 32'h110); chk_dec("addi",  A_ADD, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h110);
        send_one(32'h123450B7, 32'h114); chk_dec("lui",   A_ADD, 1'b0, 2'd2, 1'b1, 32'h12345000, 1'b0, 32'h114);
        send_one(32'hFE20CEE3, 32'h118); chk_dec("blt",   A_SLT, 1'b0, 2'd0, 1'b0, 32'hFFFFFFFC, 1'b0, 32'h118);
        send_one(32'h008000EF, 32'h11C); chk_dec("jal",   A_ADD, 1'b0, 2'd1, 1'b1, 32'd8, 1'b0, 32'h11C);
        send_one(32'h0020A623, 32'h120); chk_dec("sw",    A_ADD, 1'b0, 2'd0, 1'b1, 32'd12, 1'b0, 32'h120);
        send_one(32'h40511093, 32'h124); chk_dec("slli_f7", A_ADD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h124);
        chk("slli_f7.cnt", {48'd0, illegal_cnt}, 64'd1);
        @(negedge clk);
        chk("drain.out_valid", {63'd0, out_valid}, 64'd0);

        // Stream 8 ADDI words (imm=k) while out_ready is held low for the first 3 cycles
        sent = 0; rcv = 0;
        for (cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (sent < 8);
            in_instr  = 32'h00000093 | ((sent + 1) << 20);
            in_pc     = 32'h2000 + sent * 4;
            if (cyc == 2) chk("stream.in_ready_low", {63'd0, in_ready}, 64'd0);
            if (out_valid && out_ready) begin
                chk("stream.pc", {32'd0, pc_out}, {32'd0, exp_pc.pop_front()});
                chk("stream.imm", {32'd0, imm}, 64'(rcv + 1));
                rcv++;
            end
            if (in_valid && in_ready) begin
                exp_pc.push_back(in_pc);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stream.count", 64'(rcv), 64'd8);

        // Illegal counting from a clean counter
        out_ready = 1'b1;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        send_one(32'hFFFFFFFF, 32'h300); chk_dec("ill_ones", A_ADD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h300);
        send_one(32'h00000000, 32'h304); chk_dec("ill_zero", A_ADD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h304);
        send_one(32'h00002063, 32'h308); chk_dec("ill_br",   A_ADD, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 32'h308);
        chk("ill.cnt", {48'd0, illegal_cnt}, 64'd3);
        @(negedge clk);

        // Queue two entries, then flush while an illegal word is offered
        out_ready = 1'b0;
        send_one(32'h00100093, 32'h400);
        send_one(32'h00200093, 32'h404);
        chk("queued.in_ready", {63'd0, in_ready}, 64'd0);
        chk("queued.head_pc", {32'd0, pc_out}, 64'h400);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush.in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush.cnt", {48'd0, illegal_cnt}, 64'd3);
        chk("flush.payload", {28'd0, alu_ctrl, imm}, 64'd0);

        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("rst2.cnt", {48'd0, illegal_cnt}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
